// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/flag sequencer: opcodes, branch conditions,
// FSM state encoding and ALU function select values.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_BR  = 4'd6;
  localparam logic [3:0] OP_NOP = 4'd7;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_MI = 3'd5;
  localparam logic [2:0] COND_PL = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_WB     = 3'd3,
    ST_BRANCH = 3'd4
  } state_e;

  // Zero is reserved so the ALU sees "no function" whenever the sequencer is idle.
  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;

  function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
    logic [2:0] sel;
    sel = ALU_NONE;
    case (op)
      OP_ADD:         sel = ALU_ADD;
      OP_SUB, OP_CMP: sel = ALU_SUB;
      OP_AND:         sel = ALU_AND;
      OP_OR:          sel = ALU_OR;
      OP_SHL:         sel = ALU_SHL;
      default:        sel = ALU_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: resolves a 3-bit condition code
// against the C/Z/N flags.
module branch_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       c,
  input  logic       z,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_sequencer.sv
// Multicycle sequencer stepping one ALU/compare/shift/branch op through
// EXEC, SHIFT, WB and BRANCH, driving ALU select, shift steps and flag loads.
module alu_flag_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW = 4,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [OPW-1:0] op_code,
  input  logic [2:0]     cond,
  input  logic [SHW-1:0] shamt,
  input  logic           c_in,
  input  logic           z_in,
  input  logic           n_in,
  output logic [2:0]     alu_sel,
  output logic           shift_step,
  output logic           ld_c,
  output logic           ld_z,
  output logic           ld_n,
  output logic           reg_write,
  output logic           branch_taken,
  output logic           done,
  output logic           err
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [2:0]     cond_q, cond_d;
  logic [SHW-1:0] count_q, count_d;

  logic [3:0] in_op4, op4;
  logic       in_illegal, op_illegal;
  logic       cond_taken;

  assign in_op4     = 4'(op_code);
  assign op4        = 4'(op_q);
  assign in_illegal = op_code > OPW'(OP_NOP);
  assign op_illegal = op_q > OPW'(OP_NOP);

  branch_cond_eval u_cond (
    .cond  (cond_q),
    .c     (c_in),
    .z     (z_in),
    .n     (n_in),
    .taken (cond_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cond_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cond_d       = cond_q;
    count_d      = count_q;
    op_ready     = 1'b0;
    alu_sel      = ALU_NONE;
    shift_step   = 1'b0;
    ld_c         = 1'b0;
    ld_z         = 1'b0;
    ld_n         = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d    = op_code;
          cond_d  = cond;
          count_d = '0;
          if (in_illegal) begin
            state_d = ST_WB;
          end else begin
            case (in_op4)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP: state_d = ST_EXEC;
              OP_SHL: begin
                count_d = shamt;
                state_d = (shamt == '0) ? ST_EXEC : ST_SHIFT;
              end
              OP_BR:   state_d = ST_BRANCH;
              default: state_d = ST_WB;
            endcase
          end
        end
      end

      ST_EXEC: begin
        alu_sel = alu_sel_of(op4);
        case (op4)
          OP_ADD, OP_SUB, OP_CMP: begin
            ld_c = 1'b1;
            ld_z = 1'b1;
            ld_n = 1'b1;
          end
          // A zero-length shift produces no carry-out, so C is preserved.
          OP_AND, OP_OR, OP_SHL: begin
            ld_z = 1'b1;
            ld_n = 1'b1;
          end
          default: ;
        endcase
        state_d = ST_WB;
      end

      ST_SHIFT: begin
        alu_sel    = ALU_SHL;
        shift_step = 1'b1;
        count_d    = count_q - SHW'(1);
        if (count_q <= SHW'(1)) begin
          ld_c    = 1'b1;
          ld_z    = 1'b1;
          ld_n    = 1'b1;
          count_d = '0;
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        done = 1'b1;
        err  = op_illegal;
        if (!op_illegal) begin
          case (op4)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL: reg_write = 1'b1;
            default:                               reg_write = 1'b0;
          endcase
        end
        state_d = ST_IDLE;
      end

      ST_BRANCH: begin
        done         = 1'b1;
        branch_taken = cond_taken;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_flag_sequencer.sv
// Self-checking bench for alu_flag_sequencer: directed and random ops compared
// cycle by cycle against a latency/flag-rule model of each op.
module tb_alu_flag_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = '0;
  logic [2:0] cond = '0;
  logic [4:0] shamt = '0;
  logic       c_in = 1'b0, z_in = 1'b0, n_in = 1'b0;
  logic [2:0] alu_sel;
  logic       shift_step, ld_c, ld_z, ld_n, reg_write, branch_taken, done, err;

  int vectors = 0;
  int miscompares = 0;

  alu_flag_sequencer #(.OPW(4), .SHW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .cond         (cond),
    .shamt        (shamt),
    .c_in         (c_in),
    .z_in         (z_in),
    .n_in         (n_in),
    .alu_sel      (alu_sel),
    .shift_step   (shift_step),
    .ld_c         (ld_c),
    .ld_z         (ld_z),
    .ld_n         (ld_n),
    .reg_write    (reg_write),
    .branch_taken (branch_taken),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // {ready, alu_active, shift, ld_c, ld_z, ld_n, reg_write, taken, done, err}
  logic [9:0] obs;
  assign obs = {op_ready, (alu_sel != 3'd0), shift_step, ld_c, ld_z, ld_n,
                reg_write, branch_taken, done, err};

  localparam logic [9:0] IDLE_V = 10'b10_0000_0000;

  function automatic int lat(input int op, input int sh);
    if (op >= 6) return 1;
    if (op == 5) return (sh == 0) ? 2 : sh + 1;
    return 2;
  endfunction

  function automatic logic cond_ok(input int cd, input logic c, input logic z, input logic n);
    case (cd)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs k cycles after the accept edge (k=0: before accept).
  function automatic logic [9:0] expv(input int op, input int cd, input int sh,
                                      input logic c, input logic z, input logic n,
                                      input int k);
    int L;
    logic [9:0] v;
    L = lat(op, sh);
    v = '0;
    if (k == 0 || k > L) return IDLE_V;
    if (k < L) begin
      v[8] = 1'b1;
      v[7] = (op == 5) && (sh > 0);
      if (k == L - 1) begin
        v[5] = 1'b1;
        v[4] = 1'b1;
        v[6] = (op == 0) || (op == 1) || (op == 4) || (op == 5 && sh > 0);
      end
    end else begin
      v[1] = 1'b1;
      if (op == 6) v[2] = cond_ok(cd, c, z, n);
      else begin
        v[3] = (op == 0) || (op == 1) || (op == 2) || (op == 3) || (op == 5);
        v[0] = (op > 7);
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [9:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic run_op(input int op, input int cd, input int sh,
                        input logic c, input logic z, input logic n,
                        input bit hold, input string tag);
    int L;
    L = lat(op, sh);
    c_in = c; z_in = z; n_in = n;
    op_code = 4'(op); cond = 3'(cd); shamt = 5'(sh);
    chk({tag, "_idle"}, expv(op, cd, sh, c, z, n, 0));
    op_valid = 1'b1;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          op_code = 4'd6;
          cond = 3'(~cd);
          shamt = 5'(sh + 3);
        end else begin
          op_valid = 1'b0;
        end
      end
      chk(tag, expv(op, cd, sh, c, z, n, k));
    end
    op_valid = 1'b0;
  endtask

  initial begin
    int op, cd, sh;
    logic [2:0] f;

    // reset state
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", IDLE_V);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset", IDLE_V);

    // reset in the middle of a 9-step shift
    op_code = 4'd5; shamt = 5'd9; cond = 3'd0;
    op_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) op_valid = 1'b0;
      chk("shl9_pre_rst", expv(5, 0, 9, 0, 0, 0, k));
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_shl", IDLE_V);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_shl_after", IDLE_V);

    // directed ops
    run_op(0, 0, 0, 0, 0, 0, 0, "add");
    run_op(4, 0, 0, 0, 0, 0, 0, "cmp");
    run_op(6, 1, 0, 0, 1, 0, 0, "br_eq_z1");
    run_op(6, 2, 0, 0, 1, 0, 0, "br_ne_z1");
    run_op(5, 0, 5, 0, 0, 0, 0, "shl5");
    run_op(5, 0, 0, 1, 0, 0, 0, "shl0");
    run_op(12, 0, 0, 0, 0, 0, 0, "illegal12");
    run_op(0, 3, 2, 1, 0, 1, 1, "add_hold");
    run_op(5, 0, 3, 0, 1, 1, 1, "shl_hold");
    run_op(2, 0, 0, 1, 0, 0, 0, "and_c1");
    run_op(3, 0, 0, 1, 1, 1, 0, "or_c1");
    run_op(7, 0, 0, 1, 1, 1, 0, "nop");
    run_op(5, 0, 31, 1, 0, 1, 0, "shl31");

    // every condition against every flag combination
    for (int i = 0; i < 64; i++) begin
      f = 3'(i);
      run_op(6, i / 8, 0, f[2], f[1], f[0], 0, "br_all");
    end

    // random ops
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
      cd = int'($urandom_range(0, 7));
      sh = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 12));
      f  = 3'($urandom);
      run_op(op, cd, sh, f[2], f[1], f[0], bit'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
